// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst encodings, response codes and burst legality check.
package axi_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
    localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
    function automatic logic burst_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return size <= 3'd2 && burst != 2'b11 &&
               (burst != WRAP || len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction
endpackage

// File: rtl/axi_if.sv
// axi_if: AXI-full interface, 32-bit data and 4-bit ids, with master and slave modports.
interface axi_if;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [3:0]  rid;
    modport slave (
        output awready, input awvalid, awaddr, awid, awlen, awsize, awburst,
        output wready, input wvalid, wdata, wstrb, wlast,
        output bvalid, bresp, bid, input bready,
        output arready, input arvalid, araddr, arid, arlen, arsize, arburst,
        output rvalid, rresp, rdata, rlast, rid, input rready
    );
    modport master (
        input awready, output awvalid, awaddr, awid, awlen, awsize, awburst,
        input wready, output wvalid, wdata, wstrb, wlast,
        input bvalid, bresp, bid, output bready,
        input arready, output arvalid, araddr, arid, arlen, arsize, arburst,
        input rvalid, rresp, rdata, rlast, rid, output rready
    );
endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] nxt
);
    logic [31:0] step, mask, inc;
    always_comb begin
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        inc  = addr + step;
        nxt  = burst == FIXED ? addr : burst == WRAP ? (addr & ~mask) | (inc & mask) : inc;
    end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI-full slave over a word-wide SRAM with independent read and write FSMs.
// Define AXI_SRAM_DELAY_EN to add LFSR-driven random stalls on arready/awready/wready.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          MAX_DELAY = 7
) (
    input logic  clk,
    input logic  rst_n,
    axi_if.slave s
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int DW = $clog2(MAX_DELAY + 2);
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0]   mem [MEM_WORDS];
    r_state_t      r_state;
    w_state_t      w_state;
    logic [31:0]   ar_addr, aw_addr, r_nxt, w_nxt;
    logic [7:0]    ar_len, aw_len, r_cnt, w_cnt;
    logic [2:0]    ar_size, aw_size;
    logic [1:0]    ar_burst, aw_burst;
    logic          b_err, r_err, w_err, w_end, w_fire;
    logic [DW-1:0] ar_wait, aw_wait, w_wait, dly;

    function automatic logic in_range(input logic [31:0] a);
        return a >= ADDR_BASE && ((a - ADDR_BASE) >> 2) < 32'(MEM_WORDS);
    endfunction
    function automatic logic [IW-1:0] widx(input logic [31:0] a);
        return IW'((a - ADDR_BASE) >> 2);
    endfunction

`ifdef AXI_SRAM_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 16'hACE1;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign dly = DW'(lfsr % 16'(MAX_DELAY + 1));
`else
    assign dly = '0;
`endif

    axi_burst_addr u_raddr (.addr(ar_addr), .len(ar_len), .size(ar_size), .burst(ar_burst), .nxt(r_nxt));
    axi_burst_addr u_waddr (.addr(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst), .nxt(w_nxt));

    assign r_err  = !burst_legal(ar_len, ar_size, ar_burst) || !in_range(ar_addr);
    assign w_end  = w_cnt == aw_len;
    assign w_fire = w_state == W_DATA && s.wready && s.wvalid;
    assign w_err  = !burst_legal(aw_len, aw_size, aw_burst) || !in_range(aw_addr) || (s.wlast != w_end);

    always_ff @(posedge clk)
        if (w_fire && !w_err)
            for (int b = 0; b < 4; b++)
                if (s.wstrb[b]) mem[widx(aw_addr)][8*b +: 8] <= s.wdata[8*b +: 8];

    // A ready drop loads its wait counter; the ready rises once the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            s.arready <= 1'b0;
            s.rvalid  <= 1'b0;
            s.rdata   <= '0;
            s.rresp   <= OKAY;
            s.rlast   <= 1'b0;
            s.rid     <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_size   <= '0;
            ar_burst  <= '0;
            r_cnt     <= '0;
            ar_wait   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s.arready && s.arvalid) begin
                    s.arready <= 1'b0;
                    ar_addr   <= s.araddr;
                    ar_len    <= s.arlen;
                    ar_size   <= s.arsize;
                    ar_burst  <= s.arburst;
                    s.rid     <= s.arid;
                    r_cnt     <= '0;
                    r_state   <= R_READ;
                end else if (!s.arready) begin
                    s.arready <= (ar_wait <= DW'(1));
                    ar_wait   <= ar_wait == '0 ? '0 : ar_wait - 1'b1;
                end
                R_READ: begin
                    s.rdata  <= r_err ? '0 : mem[widx(ar_addr)];
                    s.rresp  <= r_err ? SLVERR : OKAY;
                    s.rlast  <= r_cnt == ar_len;
                    s.rvalid <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: if (s.rready) begin
                    s.rvalid <= 1'b0;
                    s.rlast  <= 1'b0;
                    if (r_cnt == ar_len) begin
                        s.arready <= dly == '0;
                        ar_wait   <= dly;
                        r_state   <= R_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        ar_addr <= r_nxt;
                        r_state <= R_READ;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b0;
            s.bresp   <= OKAY;
            s.bid     <= '0;
            aw_addr   <= '0;
            aw_len    <= '0;
            aw_size   <= '0;
            aw_burst  <= '0;
            w_cnt     <= '0;
            b_err     <= 1'b0;
            aw_wait   <= '0;
            w_wait    <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (s.awready && s.awvalid) begin
                    s.awready <= 1'b0;
                    aw_addr   <= s.awaddr;
                    aw_len    <= s.awlen;
                    aw_size   <= s.awsize;
                    aw_burst  <= s.awburst;
                    s.bid     <= s.awid;
                    w_cnt     <= '0;
                    b_err     <= 1'b0;
                    s.wready  <= dly == '0;
                    w_wait    <= dly;
                    w_state   <= W_DATA;
                end else if (!s.awready) begin
                    s.awready <= (aw_wait <= DW'(1));
                    aw_wait   <= aw_wait == '0 ? '0 : aw_wait - 1'b1;
                end
                W_DATA: if (w_fire) begin
                    b_err <= b_err | w_err;
                    if (w_end) begin
                        s.wready <= 1'b0;
                        s.bvalid <= 1'b1;
                        s.bresp  <= (b_err | w_err) ? SLVERR : OKAY;
                        w_state  <= W_RESP;
                    end else begin
                        w_cnt    <= w_cnt + 8'd1;
                        aw_addr  <= w_nxt;
                        s.wready <= dly == '0;
                        w_wait   <= dly;
                    end
                end else if (!s.wready) begin
                    s.wready <= (w_wait <= DW'(1));
                    w_wait   <= w_wait == '0 ? '0 : w_wait - 1'b1;
                end
                W_RESP: if (s.bready) begin
                    s.bvalid  <= 1'b0;
                    s.awready <= dly == '0;
                    aw_wait   <= dly;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave with hand-computed expectations.
module tb_axi_sram_slave;
    import axi_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    int total = 0, bad = 0;
    axi_if bus ();
    axi_sram_slave dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = sz; bus.awburst = bu;
        for (int n = 0; n < 50 && !bus.awready; n++) @(negedge clk);
        chk("awready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = strb; bus.wlast = last;
        for (int n = 0; n < 50 && !bus.wready; n++) @(negedge clk);
        chk("wready", bus.wready, 1);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = sz; bus.arburst = bu;
        for (int n = 0; n < 50 && !bus.arready; n++) @(negedge clk);
        chk("arready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d, output logic [1:0] rs, output logic l, output logic [3:0] id);
        bus.rready = 1'b1;
        for (int n = 0; n < 50 && !bus.rvalid; n++) @(negedge clk);
        chk("rvalid", bus.rvalid, 1);
        d = bus.rdata; rs = bus.rresp; l = bus.rlast; id = bus.rid;
        @(negedge clk);
    endtask

    task automatic get_b(output logic [1:0] rs, output logic [3:0] id);
        bus.bready = 1'b1;
        for (int n = 0; n < 50 && !bus.bvalid; n++) @(negedge clk);
        chk("bvalid", bus.bvalid, 1);
        rs = bus.bresp; id = bus.bid;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic wr1(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb, input logic [1:0] exp);
        logic [1:0] rs;
        logic [3:0] id;
        do_aw(a, 4'h0, 8'd0, 3'd2, INCR);
        do_w(d, strb, 1'b1);
        get_b(rs, id);
        chk({tag, "_bresp"}, rs, exp);
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_rs);
        logic [31:0] d;
        logic [1:0] rs;
        logic l;
        logic [3:0] id;
        do_ar(a, 4'h1, 8'd0, 3'd2, INCR);
        get_r(d, rs, l, id);
        chk({tag, "_rdata"}, d, exp_d);
        chk({tag, "_rresp"}, rs, exp_rs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0] rs;
        logic l;
        logic [3:0] id;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_arready", bus.arready, 0);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_arready", bus.arready, 1);
        chk("idle_awready", bus.awready, 1);

        // single write then read back
        do_aw(32'h8000_0010, 4'h3, 8'd0, 3'd2, INCR);
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        get_b(rs, id);
        chk("t1_bresp", rs, OKAY);
        chk("t1_bid", id, 4'h3);
        do_ar(32'h8000_0010, 4'h1, 8'd0, 3'd2, INCR);
        get_r(d, rs, l, id);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_rresp", rs, OKAY);
        chk("t1_rlast", l, 1);
        chk("t1_rid", id, 4'h1);

        // INCR write/read of words 0..3
        do_aw(32'h8000_0000, 4'h0, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) do_w(32'h1000_0000 + i, 4'hF, i == 3);
        get_b(rs, id);
        chk("incr_bresp", rs, OKAY);
        do_ar(32'h8000_0000, 4'h5, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            get_r(d, rs, l, id);
            chk("incr_rdata", d, 32'h1000_0000 + i);
            chk("incr_rlast", l, i == 3);
            chk("incr_rid", id, 4'h5);
        end

        // WRAP write from 0x38 lands at 0x38,0x3C,0x30,0x34
        do_aw(32'h8000_0038, 4'h0, 8'd3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) do_w(32'hA000_0000 + i, 4'hF, i == 3);
        get_b(rs, id);
        chk("wrap_bresp", rs, OKAY);
        do_ar(32'h8000_0030, 4'h0, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            get_r(d, rs, l, id);
            chk("wrap_rdata", d, 32'hA000_0000 + ((i + 2) % 4));
        end

        // byte strobe
        wr1("strb0", 32'h8000_0100, 32'h0, 4'hF, OKAY);
        wr1("strb1", 32'h8000_0100, 32'hAABB_CCDD, 4'b0100, OKAY);
        rd1("strb", 32'h8000_0100, 32'h00BB_0000, OKAY);

        // out-of-range write aliases to word 4095 but must not store
        wr1("top", 32'h8000_3FFC, 32'h5555_AAAA, 4'hF, OKAY);
        wr1("oor", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, SLVERR);
        rd1("oor_keep", 32'h8000_3FFC, 32'h5555_AAAA, OKAY);
        rd1("oor_lo", 32'h7FFF_FFFC, 32'h0, SLVERR);
        rd1("oor_hi", 32'h8000_4000, 32'h0, SLVERR);
        do_ar(32'h8000_0010, 4'h0, 8'd0, 3'd2, 2'b11);
        get_r(d, rs, l, id);
        chk("bad_burst_rresp", rs, SLVERR);
        chk("bad_burst_rdata", d, 32'h0);

        // early wlast: first beat dropped, second stored, bresp ORed
        do_aw(32'h8000_0100, 4'h0, 8'd1, 3'd2, INCR);
        do_w(32'h1234_0000, 4'hF, 1'b1);
        do_w(32'h0000_5678, 4'hF, 1'b1);
        get_b(rs, id);
        chk("wlast_bresp", rs, SLVERR);
        rd1("wlast_b0", 32'h8000_0100, 32'h00BB_0000, OKAY);
        rd1("wlast_b1", 32'h8000_0104, 32'h0000_5678, OKAY);

        // FIXED burst overwrites one word
        do_aw(32'h8000_0080, 4'h0, 8'd1, 3'd2, FIXED);
        do_w(32'h0000_1111, 4'hF, 1'b0);
        do_w(32'h0000_2222, 4'hF, 1'b1);
        get_b(rs, id);
        chk("fixed_bresp", rs, OKAY);
        rd1("fixed", 32'h8000_0080, 32'h0000_2222, OKAY);

        // rready backpressure mid-burst
        do_ar(32'h8000_0000, 4'h2, 8'd3, 3'd2, INCR);
        get_r(d, rs, l, id);
        chk("bp_b0", d, 32'h1000_0000);
        bus.rready = 1'b0;
        for (int n = 0; n < 50 && !bus.rvalid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_rvalid", bus.rvalid, 1);
            chk("bp_hold_rdata", bus.rdata, 32'h1000_0001);
            chk("bp_hold_rlast", bus.rlast, 0);
            chk("bp_hold_rresp", bus.rresp, OKAY);
            @(negedge clk);
        end
        for (int i = 1; i < 4; i++) begin
            get_r(d, rs, l, id);
            chk("bp_rdata", d, 32'h1000_0000 + i);
            chk("bp_rlast", l, i == 3);
        end

        // simultaneous AR and AW to one word: read sees the old value
        wr1("cc_init", 32'h8000_0200, 32'h1234_5678, 4'hF, OKAY);
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0200; bus.arid = 4'h7; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = INCR;
        bus.awvalid = 1'b1; bus.awaddr = 32'h8000_0200; bus.awid = 4'h6; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = INCR;
        chk("cc_arready", bus.arready, 1);
        chk("cc_awready", bus.awready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'h9ABC_DEF0; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        chk("cc_wready", bus.wready, 1);
        @(negedge clk);
        bus.wvalid = 1'b0;
        get_r(d, rs, l, id);
        chk("cc_old", d, 32'h1234_5678);
        get_b(rs, id);
        chk("cc_bresp", rs, OKAY);
        chk("cc_bid", id, 4'h6);
        rd1("cc_new", 32'h8000_0200, 32'h9ABC_DEF0, OKAY);

        // reset during beat 2 of a len-7 read
        do_ar(32'h8000_0000, 4'h4, 8'd7, 3'd2, INCR);
        get_r(d, rs, l, id);
        get_r(d, rs, l, id);
        chk("mid_b1", d, 32'h1000_0001);
        bus.rready = 1'b0;
        for (int n = 0; n < 50 && !bus.rvalid; n++) @(negedge clk);
        chk("mid_b2_valid", bus.rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_arready", bus.arready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_arready", bus.arready, 1);
        rd1("post_rst", 32'h8000_0010, 32'hDEAD_BEEF, OKAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
